// File: rtl/seq_chk_pkg.sv
// Shared definitions for the stream sequence checker: FSM state encoding and
// the width of the beat/burst/error counters.
package seq_chk_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/seq_chk_cmp.sv
// Beat comparator: checks data/address against the expected beat index and
// keeps the saturating error count. First-error capture under SEQ_CHK_FIRST_ERR_EN.
import seq_chk_pkg::*;

module seq_chk_cmp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  chk_en,
  input  logic [CNT_W-1:0]      beat,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      err_cnt_nxt
`ifdef SEQ_CHK_FIRST_ERR_EN
  ,
  output logic                  first_err_valid,
  output logic [CNT_W-1:0]      first_err_beat,
  output logic [DATA_WIDTH-1:0] first_err_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic                  mismatch;

  assign exp_data = DATA_WIDTH'(beat);
  assign exp_addr = ADDR_WIDTH'(beat);
  // One increment per beat, however many fields disagree.
  assign mismatch = chk_en && ((data_in != exp_data) || (addr_in != exp_addr));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr)
      err_cnt_d = '0;
    else if (mismatch)
      err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_q <= '0;
    else
      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt     = err_cnt_q;
  assign err_cnt_nxt = err_cnt_d;

`ifdef SEQ_CHK_FIRST_ERR_EN
  logic                  fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0]      fe_beat_q, fe_beat_d;
  logic [DATA_WIDTH-1:0] fe_data_q, fe_data_d;

  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_beat_d  = fe_beat_q;
    fe_data_d  = fe_data_q;
    if (clr) begin
      fe_valid_d = 1'b0;
      fe_beat_d  = '0;
      fe_data_d  = '0;
    end else if (mismatch && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_beat_d  = beat;
      fe_data_d  = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_valid_q <= 1'b0;
      fe_beat_q  <= '0;
      fe_data_q  <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_beat_q  <= fe_beat_d;
      fe_data_q  <= fe_data_d;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_beat  = fe_beat_q;
  assign first_err_data  = fe_data_q;
`endif

endmodule

// File: rtl/stream_seq_checker.sv
// Drives burst/gap request windows to a counting source and checks each beat.
// Optional first-error capture ports are enabled with SEQ_CHK_FIRST_ERR_EN.
import seq_chk_pkg::*;

module stream_seq_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int GAP_LEN    = 4
) (
  input  logic                  clk_100m,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [15:0]           n_bursts,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_cnt,
  output logic                  pass
`ifdef SEQ_CHK_FIRST_ERR_EN
  ,
  output logic                  first_err_valid,
  output logic [15:0]           first_err_beat,
  output logic [DATA_WIDTH-1:0] first_err_data
`endif
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [7:0]       LAST_GAP  = 8'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       gap_q, gap_d;
  logic             valid_out_q, valid_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             start_acc;
  logic [CNT_W-1:0] err_cnt_nxt;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          beat_d    = '0;
          gap_d     = '0;
          rem_d     = n_bursts;
          state_d   = (n_bursts == '0) ? FINISH : BURST;
        end
      end
      BURST: begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (rem_q <= CNT_ONE) begin
            rem_d   = '0;
            state_d = FINISH;
          end else begin
            rem_d   = rem_q - CNT_ONE;
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          beat_d = beat_q + CNT_ONE;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin
          gap_d   = '0;
          state_d = BURST;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered decodes of the next state so they line up with it.
    valid_out_d = (state_d == BURST);
    busy_d      = (state_d == BURST) || (state_d == GAP);
    done_d      = (state_d == FINISH);
    pass_d      = done_d && (err_cnt_nxt == '0);
  end

  always_ff @(posedge clk_100m or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  seq_chk_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp (
    .clk            (clk_100m),
    .rst            (sys_rst),
    .clr            (start_acc),
    .chk_en         (valid_out_q),
    .beat           (beat_q),
    .data_in        (data_in),
    .addr_in        (addr_in),
    .err_cnt        (err_cnt),
    .err_cnt_nxt    (err_cnt_nxt)
`ifdef SEQ_CHK_FIRST_ERR_EN
    ,
    .first_err_valid(first_err_valid),
    .first_err_beat (first_err_beat),
    .first_err_data (first_err_data)
`endif
  );

  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker with a counting source model driven
// from the test tasks; first-error checks apply when SEQ_CHK_FIRST_ERR_EN is set.
module tb_stream_seq_checker;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int BUDGET = 2000;

  logic          clk_100m = 1'b0;
  logic          sys_rst  = 1'b1;
  logic          start    = 1'b0;
  logic [15:0]   n_bursts = '0;
  logic [DW-1:0] data_in  = '0;
  logic [AW-1:0] addr_in  = '0;
  logic          valid_out, busy, done, pass;
  logic [15:0]   err_cnt;
  logic          first_err_valid;
  logic [15:0]   first_err_beat;
  logic [DW-1:0] first_err_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // Results gathered by run_stream for the calling test to check.
  int          r_vcount, r_bursts, r_min_run, r_max_run, r_min_gap, r_max_gap;
  int          r_done_lag, r_busy_bad, r_timeout, r_done;
  logic [15:0] r_err_at_done, r_err_after_start;
  logic        r_pass_at_done, r_busy_at_done;

  always #5 clk_100m = ~clk_100m;

  stream_seq_checker #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (16),
    .GAP_LEN   (4)
  ) dut (
    .clk_100m       (clk_100m),
    .sys_rst        (sys_rst),
    .start          (start),
    .n_bursts       (n_bursts),
    .data_in        (data_in),
    .addr_in        (addr_in),
    .valid_out      (valid_out),
    .busy           (busy),
    .done           (done),
    .err_cnt        (err_cnt),
    .pass           (pass)
`ifdef SEQ_CHK_FIRST_ERR_EN
    ,
    .first_err_valid(first_err_valid),
    .first_err_beat (first_err_beat),
    .first_err_data (first_err_data)
`endif
  );

`ifndef SEQ_CHK_FIRST_ERR_EN
  assign first_err_valid = 1'b0;
  assign first_err_beat  = '0;
  assign first_err_data  = '0;
`endif

  // Counting source: presents beat idx while valid_out is high, junk otherwise.
  // bad_mode: 1 = data_in forced to 5, 2 = data and addr both wrong.
  // The second fault slot always corrupts only the address.
  task automatic run_stream(input logic [15:0] nb, input int bad_burst, input int bad_beat,
                            input int bad_mode, input int bad_burst2, input int bad_beat2,
                            input bit gap_pulse);
    int idx, burst, run, gap, cyc, last_valid;
    bit in_run, seen_valid, pulsed;
    r_vcount = 0; r_bursts = 0; r_min_run = 1 << 30; r_max_run = 0;
    r_min_gap = 1 << 30; r_max_gap = 0; r_done_lag = -1; r_busy_bad = 0;
    r_timeout = 0; r_done = 0; r_err_at_done = '1; r_pass_at_done = 1'bx;
    r_busy_at_done = 1'bx;
    idx = 0; burst = 0; run = 0; gap = 0; cyc = 0; last_valid = -1;
    in_run = 0; seen_valid = 0; pulsed = 0;
    start = 1'b1;
    n_bursts = nb;
    @(posedge clk_100m); #1;
    r_err_after_start = err_cnt;
    while (r_done == 0 && cyc < BUDGET) begin
      start = 1'b0;
      if (valid_out) begin
        if (!in_run) begin
          if (seen_valid) begin
            if (gap < r_min_gap) r_min_gap = gap;
            if (gap > r_max_gap) r_max_gap = gap;
          end
          in_run = 1; run = 0;
        end
        run++; r_vcount++;
        data_in = DW'(idx);
        addr_in = AW'(idx);
        if (burst == bad_burst && idx == bad_beat) begin
          if (bad_mode == 1) data_in = DW'(5);
          if (bad_mode == 2) begin
            data_in = DW'(idx + 100);
            addr_in = AW'(idx + 100);
          end
        end
        if (burst == bad_burst2 && idx == bad_beat2) addr_in = AW'(idx) ^ AW'(32'h8000);
        if (!busy) r_busy_bad++;
        idx++; last_valid = cyc; seen_valid = 1;
      end else begin
        if (in_run) begin
          if (run < r_min_run) r_min_run = run;
          if (run > r_max_run) r_max_run = run;
          in_run = 0; burst++; idx = 0; gap = 0;
        end
        gap++;
        data_in = DW'(32'hDEAD_BEEF);
        addr_in = AW'(32'hBAD0_0000);
        if (done) begin
          r_done = 1;
          r_done_lag = cyc - last_valid;
          r_err_at_done = err_cnt;
          r_pass_at_done = pass;
          r_busy_at_done = busy;
        end else begin
          if (!busy) r_busy_bad++;
          if (gap_pulse && seen_valid && gap == 2 && !pulsed) begin
            start = 1'b1;
            n_bursts = 16'd5;
            pulsed = 1;
          end
        end
      end
      r_bursts = burst;
      @(posedge clk_100m); #1;
      cyc++;
    end
    start = 1'b0;
    if (r_done == 0) r_timeout = 1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", valid_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rst_pass got %b want 0", pass); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    repeat (2) @(posedge clk_100m);
    #3 sys_rst = 1'b0;
    @(posedge clk_100m); #1;
    n_cmp++; if (busy !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst got busy=%b valid=%b want 0/0", busy, valid_out); end
  endtask

  task automatic test_compliant();
    run_stream(16'd2, -1, -1, 0, -1, -1, 1'b0);
    n_cmp++; if (r_timeout !== 0) begin n_fail++; $display("FAIL ok_timeout got %0d want 0", r_timeout); end
    n_cmp++; if (r_vcount !== 32) begin n_fail++; $display("FAIL ok_vcount got %0d want 32", r_vcount); end
    n_cmp++; if (r_bursts !== 2) begin n_fail++; $display("FAIL ok_bursts got %0d want 2", r_bursts); end
    n_cmp++; if (r_min_run !== 16 || r_max_run !== 16) begin n_fail++; $display("FAIL ok_runlen got %0d..%0d want 16", r_min_run, r_max_run); end
    n_cmp++; if (r_min_gap !== 4 || r_max_gap !== 4) begin n_fail++; $display("FAIL ok_gaplen got %0d..%0d want 4", r_min_gap, r_max_gap); end
    n_cmp++; if (r_done_lag !== 1) begin n_fail++; $display("FAIL ok_done_lag got %0d want 1", r_done_lag); end
    n_cmp++; if (r_busy_bad !== 0) begin n_fail++; $display("FAIL ok_busy got %0d bad cycles want 0", r_busy_bad); end
    n_cmp++; if (r_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL ok_busy_done got %b want 0", r_busy_at_done); end
    n_cmp++; if (r_err_at_done !== 16'd0) begin n_fail++; $display("FAIL ok_err got %0d want 0", r_err_at_done); end
    n_cmp++; if (r_pass_at_done !== 1'b1) begin n_fail++; $display("FAIL ok_pass got %b want 1", r_pass_at_done); end
    @(posedge clk_100m); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ok_done_pulse got %b want 0", done); end
`ifdef SEQ_CHK_FIRST_ERR_EN
    n_cmp++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL ok_fe_valid got %b want 0", first_err_valid); end
`endif
  endtask

  task automatic test_single_error();
    run_stream(16'd2, 0, 3, 1, -1, -1, 1'b0);
    n_cmp++; if (r_done !== 1) begin n_fail++; $display("FAIL se_done got %0d want 1", r_done); end
    n_cmp++; if (r_err_at_done !== 16'd1) begin n_fail++; $display("FAIL se_err got %0d want 1", r_err_at_done); end
    n_cmp++; if (r_pass_at_done !== 1'b0) begin n_fail++; $display("FAIL se_pass got %b want 0", r_pass_at_done); end
`ifdef SEQ_CHK_FIRST_ERR_EN
    n_cmp++; if (first_err_valid !== 1'b1) begin n_fail++; $display("FAIL se_fe_valid got %b want 1", first_err_valid); end
    n_cmp++; if (first_err_beat !== 16'd3) begin n_fail++; $display("FAIL se_fe_beat got %0d want 3", first_err_beat); end
    n_cmp++; if (first_err_data !== DW'(5)) begin n_fail++; $display("FAIL se_fe_data got %0d want 5", first_err_data); end
`endif
    repeat (3) @(posedge clk_100m);
    #1;
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL se_err_hold got %0d want 1", err_cnt); end
  endtask

  task automatic test_multi_field();
    // Burst 1 beat 0 has both fields wrong; burst 0 beat 15 has only addr wrong.
    run_stream(16'd2, 1, 0, 2, 0, 15, 1'b0);
    n_cmp++; if (r_err_after_start !== 16'd0) begin n_fail++; $display("FAIL mf_clear_on_start got %0d want 0", r_err_after_start); end
    n_cmp++; if (r_err_at_done !== 16'd2) begin n_fail++; $display("FAIL mf_err got %0d want 2", r_err_at_done); end
    n_cmp++; if (r_pass_at_done !== 1'b0) begin n_fail++; $display("FAIL mf_pass got %b want 0", r_pass_at_done); end
`ifdef SEQ_CHK_FIRST_ERR_EN
    n_cmp++; if (first_err_beat !== 16'd15) begin n_fail++; $display("FAIL mf_fe_beat got %0d want 15", first_err_beat); end
`endif
  endtask

  task automatic test_zero_bursts();
    start = 1'b1;
    n_bursts = 16'd0;
    @(posedge clk_100m); #1;
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zb_done got %b want 1", done); end
    n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL zb_pass got %b want 1", pass); end
    n_cmp++; if (valid_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zb_idle got valid=%b busy=%b want 0/0", valid_out, busy); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL zb_err got %0d want 0", err_cnt); end
    @(posedge clk_100m); #1;
    n_cmp++; if (done !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL zb_after got done=%b valid=%b want 0/0", done, valid_out); end
  endtask

  task automatic test_reset_mid_burst();
    int idx;
    int done_seen;
    idx = 0;
    done_seen = 0;
    start = 1'b1;
    n_bursts = 16'd2;
    @(posedge clk_100m); #1;
    start = 1'b0;
    while (idx < 7 && valid_out === 1'b1) begin
      data_in = DW'(idx);
      addr_in = AW'(idx);
      idx++;
      @(posedge clk_100m); #1;
    end
    n_cmp++; if (valid_out !== 1'b1 || idx !== 7) begin n_fail++; $display("FAIL rm_reach_beat7 got valid=%b idx=%0d want 1/7", valid_out, idx); end
    data_in = DW'(7);
    addr_in = AW'(7);
    #2 sys_rst = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rm_valid_async got %b want 0", valid_out); end
    n_cmp++; if (busy !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_state got busy=%b err=%0d want 0/0", busy, err_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_100m); #1;
      if (done !== 1'b0) done_seen++;
    end
    #2 sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_100m); #1;
      if (done !== 1'b0) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL rm_no_done got %0d pulses want 0", done_seen); end
    run_stream(16'd1, -1, -1, 0, -1, -1, 1'b0);
    n_cmp++; if (r_vcount !== 16 || r_bursts !== 1) begin n_fail++; $display("FAIL rm_rerun got vcount=%0d bursts=%0d want 16/1", r_vcount, r_bursts); end
    n_cmp++; if (r_pass_at_done !== 1'b1 || r_err_at_done !== 16'd0) begin n_fail++; $display("FAIL rm_rerun_pass got pass=%b err=%0d want 1/0", r_pass_at_done, r_err_at_done); end
  endtask

  task automatic test_start_in_gap();
    run_stream(16'd3, -1, -1, 0, -1, -1, 1'b1);
    n_cmp++; if (r_timeout !== 0) begin n_fail++; $display("FAIL sg_timeout got %0d want 0", r_timeout); end
    n_cmp++; if (r_bursts !== 3 || r_vcount !== 48) begin n_fail++; $display("FAIL sg_bursts got bursts=%0d vcount=%0d want 3/48", r_bursts, r_vcount); end
    n_cmp++; if (r_min_gap !== 4 || r_max_gap !== 4) begin n_fail++; $display("FAIL sg_gaplen got %0d..%0d want 4", r_min_gap, r_max_gap); end
    n_cmp++; if (r_pass_at_done !== 1'b1) begin n_fail++; $display("FAIL sg_pass got %b want 1", r_pass_at_done); end
  endtask

  task automatic test_back_to_back();
    run_stream(16'd1, -1, -1, 0, -1, -1, 1'b0);
    @(posedge clk_100m); #1;
    run_stream(16'd1, 0, 0, 1, -1, -1, 1'b0);
    n_cmp++; if (r_vcount !== 16 || r_err_at_done !== 16'd1) begin n_fail++; $display("FAIL bb_second got vcount=%0d err=%0d want 16/1", r_vcount, r_err_at_done); end
  endtask

  initial begin
    test_reset();
    test_compliant();
    test_single_error();
    test_multi_field();
    test_zero_bursts();
    test_reset_mid_burst();
    test_start_in_gap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data_in.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of addr_in.
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per burst, range 1..65535.
REQ-004 SHALL have parameter GAP_LEN, default 4, idle cycles between bursts, range 1..255.
REQ-005 SHALL have port clk_100m, input, 1, the single clock, rising edge.
REQ-006 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begins a run of n_bursts bursts.
REQ-008 SHALL have port n_bursts, input, 16, bursts per run, sampled on start.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, incrementing data from the source.
REQ-010 SHALL have port addr_in, input, ADDR_WIDTH, incrementing address from the source.
REQ-011 SHALL have port valid_out, output, 1, beat request/window to the source.
REQ-012 SHALL have port busy, output, 1, high while a run is in progress.
REQ-013 SHALL have port done, output, 1, single-cycle pulse at the end of a run.
REQ-014 SHALL have port err_cnt, output, 16, mismatched beats in the current or last run.
REQ-015 SHALL have port pass, output, 1, valid with done, 1 iff err_cnt==0.

Function
REQ-016 SHALL implement FSM states IDLE, BURST, GAP, FINISH.
REQ-017 IDLE: start=1 SHALL latch n_bursts, clear err_cnt and go to BURST; n_bursts==0 SHALL go directly to FINISH.
REQ-018 BURST: valid_out=1 for exactly BURST_LEN consecutive cycles, then GAP if bursts remain, else FINISH.
REQ-019 Beat i (0-based, sampled on the same edge as valid_out=1) SHALL expect data_in==i and addr_in==i, zero-extended to each width.
REQ-020 Any field mismatch on a beat SHALL increment err_cnt by exactly 1 per beat; err_cnt SHALL saturate at 16'hFFFF.
REQ-021 GAP: valid_out=0 for exactly GAP_LEN cycles, then BURST; the beat index SHALL restart at 0 each burst.
REQ-022 Data and address SHALL NOT be checked while valid_out=0.
REQ-023 FINISH: done=1 and pass valid for one cycle, then IDLE; err_cnt SHALL hold until the next start.
REQ-024 start SHALL be ignored while busy=1; busy=1 in BURST and GAP, and 0 in IDLE and FINISH.
REQ-025 All outputs SHALL be registered; valid_out SHALL rise on the first edge after start is accepted.

Reset
REQ-026 sys_rst SHALL asynchronously force IDLE, valid_out=0, busy=0, done=0, pass=0, err_cnt=0, and clear all counters.
REQ-027 Reset mid-burst SHALL drop valid_out immediately with no done pulse.

Configuration
REQ-028 With macro SEQ_CHK_FIRST_ERR_EN defined, SHALL add outputs first_err_valid (1), first_err_beat (16) and first_err_data (DATA_WIDTH), capturing the burst-relative beat index and data_in of the first mismatch in a run; these SHALL be cleared on start and on reset.
REQ-029 Without SEQ_CHK_FIRST_ERR_EN, those ports and registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package seq_chk_pkg SHALL hold the FSM state typedef and the 16-bit counter width constant.
REQ-031 A sub-module seq_chk_cmp SHALL perform the compare and saturating error count; the FSM and counters SHALL remain in the top module.

Verification
REQ-032 Compliant source, n_bursts=2, BURST_LEN=16, GAP_LEN=4 -> 32 valid_out cycles in two runs of 16 separated by 4 low cycles, done after the second burst, err_cnt=0, pass=1.
REQ-033 Source forces data_in=5 on beat 3 of burst 0 -> err_cnt=1, pass=0; with the macro defined, first_err_beat=3 and first_err_data=5.
REQ-034 Both data_in and addr_in wrong on the same beat -> err_cnt increments by 1, not 2.
REQ-035 start=1 with n_bursts=0 -> no valid_out cycles, done one cycle later, pass=1.
REQ-036 sys_rst asserted at beat 7 of burst 0 -> valid_out=0 without a clock edge, no done, then a new start runs normally.
REQ-037 start pulsed during GAP -> ignored, and the run completes with the original n_bursts.
